// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// One result bit per clock: shift-add for multiply, restoring divide for
// divide. Signed ops run on magnitudes and get their signs fixed in FIX.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i2,
    input  logic [WIDTH-1:0] a_i32,
    input  logic [WIDTH-1:0] b_i32,
    input  logic             flush_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o32,
    output logic [WIDTH-1:0] lo_o32
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [1:0]         op_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic               dbz_r;
    // acc_r:low_r is the product register (multiply) or remainder:quotient (divide)
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   low_r;
    // multiplicand |a| for multiply, divisor |b| for divide
    logic [WIDTH-1:0]   opnd_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH-1:0]   acc_nxt_s;
    logic [WIDTH-1:0]   low_nxt_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_neg_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // Magnitude of an operand; only signed ops strip the sign.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return ~v + WIDTH'(1);
        end else begin
            return v;
        end
    endfunction

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign hi_o32 = hi_r;
    assign lo_o32 = lo_r;

    // One iteration of the shared add/subtract-shift datapath.
    always_comb begin
        add_s     = {1'b0, acc_r} + {1'b0, opnd_r};
        sub_s     = {acc_r, low_r[WIDTH-1]} - {1'b0, opnd_r};
        acc_nxt_s = acc_r;
        low_nxt_s = low_r;
        if (op_r[1] == 1'b0) begin
            // multiply: conditionally add multiplicand, then shift right
            if (low_r[0]) begin
                acc_nxt_s = add_s[WIDTH:1];
                low_nxt_s = {add_s[0], low_r[WIDTH-1:1]};
            end else begin
                acc_nxt_s = {1'b0, acc_r[WIDTH-1:1]};
                low_nxt_s = {acc_r[0], low_r[WIDTH-1:1]};
            end
        end else begin
            // divide: shift in next dividend bit, keep difference if non-negative
            if (sub_s[WIDTH] == 1'b0) begin
                acc_nxt_s = sub_s[WIDTH-1:0];
                low_nxt_s = {low_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = {acc_r[WIDTH-2:0], low_r[WIDTH-1]};
                low_nxt_s = {low_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and final HI/LO selection, used at the FIX edge.
    always_comb begin
        prod_s     = {acc_r, low_r};
        prod_neg_s = ~prod_s + (2*WIDTH)'(1);
        fix_hi_s   = acc_r;
        fix_lo_s   = low_r;
        if (op_r[1] == 1'b0) begin
            if (op_r[0] && (sign_a_r ^ sign_b_r)) begin
                fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
                fix_lo_s = prod_neg_s[WIDTH-1:0];
            end else begin
                fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
                fix_lo_s = prod_s[WIDTH-1:0];
            end
        end else begin
            // remainder takes the dividend's sign; with b=0 it equals the original a
            if (op_r[0] && sign_a_r) begin
                fix_hi_s = ~acc_r + WIDTH'(1);
            end else begin
                fix_hi_s = acc_r;
            end
            if (dbz_r) begin
                fix_lo_s = {WIDTH{1'b1}};
            end else if (op_r[0] && (sign_a_r ^ sign_b_r)) begin
                fix_lo_s = ~low_r + WIDTH'(1);
            end else begin
                fix_lo_s = low_r;
            end
        end
    end

    // Sequencer FSM with registered busy/done and the HI/LO registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            op_r     <= 2'b00;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            dbz_r    <= 1'b0;
            acc_r    <= '0;
            low_r    <= '0;
            opnd_r   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (mthi_i) begin
                        hi_r <= a_i32;
                    end
                    if (mtlo_i) begin
                        lo_r <= a_i32;
                    end
                    if (start_i) begin
                        op_r     <= op_i2;
                        sign_a_r <= op_i2[0] & a_i32[WIDTH-1];
                        sign_b_r <= op_i2[0] & b_i32[WIDTH-1];
                        dbz_r    <= op_i2[1] & (b_i32 == '0);
                        cnt_r    <= '0;
                        acc_r    <= '0;
                        if (op_i2[1]) begin
                            low_r  <= abs_val(a_i32, op_i2[0]);
                            opnd_r <= abs_val(b_i32, op_i2[0]);
                        end else begin
                            low_r  <= abs_val(b_i32, op_i2[0]);
                            opnd_r <= abs_val(a_i32, op_i2[0]);
                        end
                        busy_r  <= 1'b1;
                        state_r <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        acc_r <= acc_nxt_s;
                        low_r <= low_nxt_s;
                        cnt_r <= cnt_r + CW'(1);
                        if (cnt_r == CW'(WIDTH-1)) begin
                            state_r <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush_i) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        hi_r    <= fix_hi_s;
                        lo_r    <= fix_lo_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // reference model state
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_rhi;
    logic [31:0] m_rlo;
    int          m_cnt;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .op_i2   (op),
        .a_i32   (a),
        .b_i32   (b),
        .flush_i (flush),
        .mthi_i  (mthi),
        .mtlo_i  (mtlo),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o32  (hi),
        .lo_o32  (lo)
    );

    always #5 clk = ~clk;

    // Architectural result {HI, LO} of an operation.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        case (o)
            2'd0: begin
                up = {32'd0, x} * {32'd0, y};
                return up;
            end
            2'd1: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return 64'(sp);
            end
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
        endcase
    endfunction

    // Cycle-level model: an accepted start completes 33 edges later unless flushed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy <= 1'b0;
                end else if (m_cnt == 32) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_rhi;
                    m_lo   <= m_rlo;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                if (mthi) m_hi <= a;
                if (mtlo) m_lo <= a;
                if (start) begin
                    {m_rhi, m_rlo} <= ref_result(op, a, b);
                    m_busy <= 1'b1;
                    m_cnt  <= 0;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            n_cmp++;
            if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t got busy=%0b done=%0b hi=%h lo=%h, want busy=%0b done=%0b hi=%h lo=%h",
                         $time, busy, done, hi, lo, m_busy, m_done, m_hi, m_lo);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Launch one op at posedge+1; returns with time at posedge+1 of the done
    // cycle (or of the cycle after the flush edge).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inj_cyc, input int fl_cyc,
                          output int cyc, output bit got_done, output int bc);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        cyc = 0; got_done = 1'b0; bc = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            if (inj_cyc != 0 && cyc == inj_cyc) begin
                start = 1'b1; mthi = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            flush = (fl_cyc != 0 && cyc == fl_cyc);
            @(posedge clk); cyc++; #1;
            if (busy) bc++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (fl_cyc != 0 && cyc == fl_cyc + 1) break;
        end
        start = 1'b0; mthi = 1'b0; flush = 1'b0;
    endtask

    int cyc;
    bit gd;
    int bc;

    initial begin
        rst_n = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(posedge clk); #1;

        // MULT -3 * 5
        run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 0, 0, cyc, gd, bc);
        chk("mult_done", 32'(gd), 32'd1);
        chk("mult_latency", 32'(cyc), 32'd33);
        chk("mult_busy_cycles", 32'(bc), 32'd33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        // MULTU max*max, then DIVU started in the done cycle
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, cyc, gd, bc);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        run_op(2'd2, 32'd100, 32'd7, 0, 0, cyc, gd, bc);
        chk("divu_b2b_latency", 32'(cyc), 32'd33);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'hE);

        // signed divides
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, cyc, gd, bc);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, cyc, gd, bc);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);

        // divide by zero with ignored start/mthi mid-operation
        run_op(2'd2, 32'h0000_1234, 32'd0, 5, 0, cyc, gd, bc);
        chk("dbz_latency", 32'(cyc), 32'd33);
        chk("dbz_lo", lo, 32'hFFFF_FFFF);
        chk("dbz_hi", hi, 32'h0000_1234);

        // MTLO then flushed MULT
        mtlo = 1'b1; a = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'hA5A5_A5A5);
        run_op(2'd1, 32'd123, 32'd456, 0, 10, cyc, gd, bc);
        chk("flush_no_done", 32'(gd), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_lo", lo, 32'hA5A5_A5A5);
        chk("flush_hi", hi, 32'h0000_1234);

        // asynchronous reset mid-CALC
        start = 1'b1; op = 2'd1; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'd0, 32'd3, 32'd4, 0, 0, cyc, gd, bc);
        chk("post_rst_lo", lo, 32'hC);
        chk("post_rst_hi", hi, 32'd0);

        // randomized traffic, checked by the per-cycle model comparison
        repeat (2500) begin
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 79) == 0);
            mthi  = ($urandom_range(0, 9) == 0);
            mtlo  = ($urandom_range(0, 9) == 0);
            op    = 2'($urandom);
            a     = pick();
            b     = pick();
            @(posedge clk); #1;
        end
        start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. It owns the HI/LO registers and iterates one bit per clock with an internal add/subtract-shift datapath.
- Sits beside the single-cycle ALU in the execute stage. The hazard logic stalls on busy_o, and MFHI/MFLO read hi_o32/lo_o32 directly.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  request a new operation; sampled only in IDLE
- op_i2  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a_i32  in  WIDTH  multiplicand / dividend
- b_i32  in  WIDTH  multiplier / divisor
- flush_i  in  1  abort the in-flight operation
- mthi_i  in  1  write a_i32 into HI
- mtlo_i  in  1  write a_i32 into LO
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle pulse: HI/LO just updated by a completed operation
- hi_o32  out  WIDTH  HI register
- lo_o32  out  WIDTH  LO register

Behaviour:
- Reset (rst_ni=0, asynchronous, takes effect at any time including mid-operation):
  - state=IDLE; busy_o, done_o, HI, LO, counter and all working registers = 0.
- State machine:
  - IDLE -> CALC -> FIX -> IDLE.
  - flush_i=1 in CALC or FIX -> IDLE at the next edge. HI/LO unchanged, done_o stays 0.
  - flush_i in IDLE has no effect.
- Start (edge E0, IDLE with start_i=1):
  - Latch op, |a| and |b| (absolute values only for signed ops), sign_a, sign_b; counter=0.
  - Next state CALC; busy_o=1 from E0 onward.
- CALC, edges E1..E32:
  - Multiply: shift-add over a 64-bit product register.
  - Divide: restoring divide; each bit subtracts, keeps the remainder when the difference is non-negative, and shifts the quotient bit in.
  - Counter increments; on counter=WIDTH-1 the next state is FIX.
- FIX, edge E33:
  - Signed ops only: negate the product if sign_a^sign_b; negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Write HI (product[63:32] / remainder) and LO (product[31:0] / quotient).
  - done_o=1 for exactly the one cycle after E33; busy_o=0 in that same cycle; next state IDLE.
- Latency:
  - 33 clocks from the start-sampling edge to done.
  - A new start may be sampled in the done cycle (back-to-back).
- Divide by zero:
  - No exception; still takes full latency.
  - LO=all ones; HI=original a_i32, for both DIV and DIVU.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- start_i while busy_o=1: ignored; no queuing.
- mthi_i/mtlo_i:
  - Honoured only when busy_o=0; ignored while busy.
  - In IDLE, mthi/mtlo and start at the same edge: the move writes HI/LO now, and the completing operation overwrites it at E33.
  - mthi_i and mtlo_i together: both written with a_i32.
- Operands and op are captured only at E0; later changes on a_i32/b_i32/op_i2 have no effect.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> done 33 cycles after start: HI=0xFFFFFFFF, LO=0xFFFFFFF1. busy_o high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then DIVU 100/7 started in the done cycle -> HI=2, LO=0xE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234. Also start_i pulsed and mthi_i asserted mid-operation -> both ignored.
- mtlo_i with a=0xA5A5A5A5 in IDLE -> LO=0xA5A5A5A5 next cycle. Then MULT started, flush_i at cycle 10 -> busy_o=0 next cycle, no done_o, LO still 0xA5A5A5A5.
- rst_ni low for 3 ns mid-CALC (asynchronous, between edges) -> busy_o, HI, LO = 0 immediately. After release a fresh MULTU 3*4 gives LO=0xC.
